bundle_fetch_buffer: RTL and testbench

- Fetch stage directly upstream of slot_valid and the enqueue logic.
- Generates sequential bundle fetch addresses to the I-cache and reserves a buffer entry for every granted request.
- Fills entries with in-order I-cache responses and presents the head bundle as phit / bundle / bundle_ip / ip_mask.
- Pops the head on nextb; discards all fetch state on redirect (branchmiss).

---
 rtl/bundle_fetch_buffer.sv | 122 ++++++++++++
 tb/tb_bundle_fetch_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bundle_fetch_buffer.sv
// Sequential bundle fetch: issues I-cache requests, reserves an entry per grant,
// fills entries from epoch-tagged in-order responses and presents the head bundle.
module bundle_fetch_buffer #(
    parameter int unsigned   DEPTH  = 4,
    parameter int unsigned   AW     = 32,
    parameter int unsigned   BW     = 128,
    parameter int unsigned   EPW    = 2,
    parameter logic [AW-1:0] RST_IP = AW'(32'hFFFC_0000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [AW-1:0]            redirect_ip,
    output logic                     ic_req,
    output logic [AW-1:0]            ic_req_addr,
    output logic [EPW-1:0]           ic_req_epoch,
    input  logic                     ic_gnt,
    input  logic                     ic_rsp_valid,
    input  logic [EPW-1:0]           ic_rsp_epoch,
    input  logic [BW-1:0]            ic_rsp_bundle,
    input  logic                     nextb,
    output logic                     phit,
    output logic [BW-1:0]            bundle,
    output logic [AW-1:0]            bundle_ip,
    output logic [2:0]               ip_mask,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    logic [AW-1:0]  pc;
    logic [OW-1:0]  rp;
    logic [OW-1:0]  fp;
    logic [OW-1:0]  wp;
    logic [EPW-1:0] epoch;
    logic [DEPTH-1:0] filled;

    logic [AW-1:0] ent_ip   [DEPTH];
    logic [2:0]    ent_mask [DEPTH];
    logic [BW-1:0] ent_data [DEPTH];

    logic [PW-1:0] rp_idx;
    logic [PW-1:0] fp_idx;
    logic [PW-1:0] wp_idx;
    logic          alloc_c;
    logic          fill_c;
    logic          pop_c;
    logic [2:0]    alloc_mask_c;

    assign rp_idx = rp[PW-1:0];
    assign fp_idx = fp[PW-1:0];
    assign wp_idx = wp[PW-1:0];

    // Request side uses registered occupancy, so a pop never frees a slot in the same cycle.
    assign occ          = wp - rp;
    assign ic_req       = !rst && !redirect && (occ < OW'(DEPTH));
    assign ic_req_addr  = {pc[AW-1:4], 4'b0000};
    assign ic_req_epoch = epoch;

    assign alloc_c = ic_req && ic_gnt;
    assign fill_c  = !redirect && ic_rsp_valid && (ic_rsp_epoch == epoch) && (fp != wp);
    assign phit    = filled[rp_idx] && (rp != fp);
    assign pop_c   = !redirect && nextb && phit;

    assign bundle    = ent_data[rp_idx];
    assign bundle_ip = ent_ip[rp_idx];
    assign ip_mask   = ent_mask[rp_idx];

    // Valid-slot mask for the bundle at pc; slot 3 start yields an empty but poppable entry.
    always_comb begin
        alloc_mask_c = 3'b000;
        case (pc[3:2])
            2'd0:    alloc_mask_c = 3'b111;
            2'd1:    alloc_mask_c = 3'b011;
            2'd2:    alloc_mask_c = 3'b001;
            default: alloc_mask_c = 3'b000;
        endcase
    end

    // Pointer, epoch and entry state; redirect discards everything and bumps the epoch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RST_IP;
            rp     <= '0;
            fp     <= '0;
            wp     <= '0;
            epoch  <= '0;
            filled <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_ip[PW'(i)]   <= '0;
                ent_mask[PW'(i)] <= '0;
                ent_data[PW'(i)] <= '0;
            end
        end else if (redirect) begin
            pc     <= redirect_ip;
            rp     <= '0;
            fp     <= '0;
            wp     <= '0;
            filled <= '0;
            epoch  <= epoch + EPW'(1);
        end else begin
            if (alloc_c) begin
                ent_ip[wp_idx]   <= pc;
                ent_mask[wp_idx] <= alloc_mask_c;
                filled[wp_idx]   <= 1'b0;
                wp               <= wp + OW'(1);
                pc               <= {pc[AW-1:4] + (AW-4)'(1), 4'b0000};
            end
            if (fill_c) begin
                ent_data[fp_idx] <= ic_rsp_bundle;
                filled[fp_idx]   <= 1'b1;
                fp               <= fp + OW'(1);
            end
            if (pop_c) begin
                filled[rp_idx] <= 1'b0;
                rp             <= rp + OW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bundle_fetch_buffer.sv
// Self-checking bench for bundle_fetch_buffer: directed scenarios plus a randomized
// run against a queue-based reference model of the fetch buffer and I-cache.
module tb_bundle_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned BW    = 128;
    localparam int unsigned EPW   = 2;

    typedef struct {
        logic [AW-1:0] ip;
        logic [2:0]    mask;
        logic [BW-1:0] data;
    } ent_t;

    typedef struct {
        logic [EPW-1:0] ep;
        logic [BW-1:0]  data;
    } req_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           redirect;
    logic [AW-1:0]  redirect_ip;
    logic           ic_req;
    logic [AW-1:0]  ic_req_addr;
    logic [EPW-1:0] ic_req_epoch;
    logic           ic_gnt;
    logic           ic_rsp_valid;
    logic [EPW-1:0] ic_rsp_epoch;
    logic [BW-1:0]  ic_rsp_bundle;
    logic           nextb;
    logic           phit;
    logic [BW-1:0]  bundle;
    logic [AW-1:0]  bundle_ip;
    logic [2:0]     ip_mask;
    logic [2:0]     occ;

    int n_cmp = 0;
    int n_err = 0;
    logic [BW-1:0] fill_d [4];

    bundle_fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .BW(BW), .EPW(EPW)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_ip(redirect_ip),
        .ic_req(ic_req), .ic_req_addr(ic_req_addr), .ic_req_epoch(ic_req_epoch),
        .ic_gnt(ic_gnt), .ic_rsp_valid(ic_rsp_valid), .ic_rsp_epoch(ic_rsp_epoch),
        .ic_rsp_bundle(ic_rsp_bundle), .nextb(nextb), .phit(phit), .bundle(bundle),
        .bundle_ip(bundle_ip), .ip_mask(ip_mask), .occ(occ)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rnd_bundle();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [2:0] mask_of(input logic [1:0] slot);
        logic [2:0] tbl [4];
        tbl[0] = 3'b111; tbl[1] = 3'b011; tbl[2] = 3'b001; tbl[3] = 3'b000;
        return tbl[slot];
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        redirect = 1'b0; redirect_ip = '0; ic_gnt = 1'b0; ic_rsp_valid = 1'b0;
        ic_rsp_epoch = '0; ic_rsp_bundle = '0; nextb = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        if (ic_req !== 1'b0) begin n_err++; $display("FAIL reset_req_in_rst got=%0b exp=0", ic_req); end n_cmp++;
        nxt(); nxt();
        rst = 1'b0;
        #1;
        if (occ !== 3'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occ); end n_cmp++;
        if (phit !== 1'b0) begin n_err++; $display("FAIL reset_phit got=%0b exp=0", phit); end n_cmp++;
        if (ip_mask !== 3'b000) begin n_err++; $display("FAIL reset_mask got=%b exp=000", ip_mask); end n_cmp++;
        if (bundle !== '0) begin n_err++; $display("FAIL reset_bundle got=%h exp=0", bundle); end n_cmp++;
        if (bundle_ip !== '0) begin n_err++; $display("FAIL reset_bundle_ip got=%h exp=0", bundle_ip); end n_cmp++;
        if (ic_req !== 1'b1) begin n_err++; $display("FAIL reset_req_after got=%0b exp=1", ic_req); end n_cmp++;
        if (ic_req_addr !== 32'hFFFC0000) begin n_err++; $display("FAIL reset_addr got=%h exp=fffc0000", ic_req_addr); end n_cmp++;
        if (ic_req_epoch !== 2'd0) begin n_err++; $display("FAIL reset_epoch got=%0d exp=0", ic_req_epoch); end n_cmp++;
    endtask

    // Grant every cycle, answer each grant two cycles later, never pop.
    task automatic test_fill_sequence();
        for (int i = 0; i < 4; i++) fill_d[i] = rnd_bundle();
        for (int k = 0; k < 10; k++) begin
            idle();
            ic_gnt = 1'b1;
            if (k >= 2 && k < 6) begin
                ic_rsp_valid = 1'b1; ic_rsp_epoch = 2'd0; ic_rsp_bundle = fill_d[k-2];
            end
            #1;
            if (ic_req !== (k < 4)) begin n_err++; $display("FAIL seq_req k=%0d got=%0b exp=%0b", k, ic_req, k < 4); end n_cmp++;
            if (k < 4) begin
                if (ic_req_addr !== 32'hFFFC0000 + 32'(k * 16)) begin n_err++; $display("FAIL seq_addr k=%0d got=%h exp=%h", k, ic_req_addr, 32'hFFFC0000 + 32'(k * 16)); end n_cmp++;
            end
            if (occ !== 3'((k < 4) ? k : 4)) begin n_err++; $display("FAIL seq_occ k=%0d got=%0d", k, occ); end n_cmp++;
            if (phit !== (k >= 3)) begin n_err++; $display("FAIL seq_phit k=%0d got=%0b exp=%0b", k, phit, k >= 3); end n_cmp++;
            if (k == 3) begin
                if (ip_mask !== 3'b111) begin n_err++; $display("FAIL seq_mask got=%b exp=111", ip_mask); end n_cmp++;
                if (bundle !== fill_d[0]) begin n_err++; $display("FAIL seq_bundle got=%h exp=%h", bundle, fill_d[0]); end n_cmp++;
            end
            nxt();
        end
    endtask

    task automatic test_full_hold();
        for (int k = 0; k < 10; k++) begin
            idle();
            #1;
            if (ic_req !== 1'b0 || occ !== 3'd4) begin n_err++; $display("FAIL hold_req_occ k=%0d req=%0b occ=%0d exp req=0 occ=4", k, ic_req, occ); end n_cmp++;
            if (phit !== 1'b1 || bundle !== fill_d[0] || bundle_ip !== 32'hFFFC0000) begin
                n_err++; $display("FAIL hold_stable k=%0d phit=%0b ip=%h bundle=%h", k, phit, bundle_ip, bundle);
            end n_cmp++;
            nxt();
        end
        nextb = 1'b1;
        #1;
        nxt();
        nextb = 1'b0;
        #1;
        if (ic_req !== 1'b1) begin n_err++; $display("FAIL hold_reassert got=%0b exp=1", ic_req); end n_cmp++;
        if (occ !== 3'd3) begin n_err++; $display("FAIL hold_pop_occ got=%0d exp=3", occ); end n_cmp++;
        if (bundle_ip !== 32'hFFFC0010 || bundle !== fill_d[1]) begin n_err++; $display("FAIL hold_next_head ip=%h exp=fffc0010", bundle_ip); end n_cmp++;
        if (ic_req_addr !== 32'hFFFC0040) begin n_err++; $display("FAIL hold_next_addr got=%h exp=fffc0040", ic_req_addr); end n_cmp++;
    endtask

    task automatic test_redirect_slot();
        logic [BW-1:0] q[$];
        logic [AW-1:0] pip [2];
        logic [2:0]    pmask [2];
        int            npop = 0;
        logic          gn;
        idle();
        redirect = 1'b1; redirect_ip = 32'h0000_1008; ic_gnt = 1'b1; nextb = 1'b1;
        #1;
        if (ic_req !== 1'b0) begin n_err++; $display("FAIL slot_redir_req got=%0b exp=0", ic_req); end n_cmp++;
        nxt();
        for (int k = 0; k < 20 && npop < 2; k++) begin
            idle();
            ic_gnt = 1'b1; nextb = 1'b1;
            if (q.size() > 0) begin
                ic_rsp_valid = 1'b1; ic_rsp_epoch = 2'd1; ic_rsp_bundle = q[0];
            end
            #1;
            if (k == 0) begin
                if (occ !== 3'd0 || ic_req_addr !== 32'h1000 || ic_req_epoch !== 2'd1) begin
                    n_err++; $display("FAIL slot_after occ=%0d addr=%h ep=%0d exp 0/1000/1", occ, ic_req_addr, ic_req_epoch);
                end n_cmp++;
            end
            if (phit) begin pip[npop] = bundle_ip; pmask[npop] = ip_mask; npop++; end
            gn = ic_req && ic_gnt;
            if (ic_rsp_valid) void'(q.pop_front());
            nxt();
            if (gn) q.push_back(rnd_bundle());
        end
        if (npop < 2) begin n_err++; $display("FAIL slot_timeout pops=%0d exp=2", npop); end
        else begin
            if (pip[0] !== 32'h1008 || pmask[0] !== 3'b001) begin n_err++; $display("FAIL slot_first ip=%h mask=%b exp 1008/001", pip[0], pmask[0]); end
            n_cmp++;
            if (pip[1] !== 32'h1010 || pmask[1] !== 3'b111) begin n_err++; $display("FAIL slot_second ip=%h mask=%b exp 1010/111", pip[1], pmask[1]); end
        end
        n_cmp++;
    endtask

    task automatic test_stale_drop();
        logic [BW-1:0] x;
        x = rnd_bundle();
        do_reset();
        ic_gnt = 1'b1;
        #1;
        if (occ !== 3'd0 || phit !== 1'b0 || ic_req_epoch !== 2'd0) begin n_err++; $display("FAIL stale_midreset occ=%0d phit=%0b ep=%0d", occ, phit, ic_req_epoch); end n_cmp++;
        nxt();
        ic_gnt = 1'b1; #1; nxt();
        ic_gnt = 1'b1; #1; nxt();
        redirect = 1'b1; redirect_ip = 32'h2000; ic_gnt = 1'b1;
        #1;
        if (occ !== 3'd3 || ic_req !== 1'b0) begin n_err++; $display("FAIL stale_redir occ=%0d req=%0b exp 3/0", occ, ic_req); end n_cmp++;
        nxt();
        redirect = 1'b0; ic_gnt = 1'b1;
        ic_rsp_valid = 1'b1; ic_rsp_epoch = 2'd0; ic_rsp_bundle = rnd_bundle();
        #1;
        if (ic_req_epoch !== 2'd1 || occ !== 3'd0 || ic_req_addr !== 32'h2000) begin n_err++; $display("FAIL stale_new ep=%0d occ=%0d addr=%h", ic_req_epoch, occ, ic_req_addr); end n_cmp++;
        nxt();
        for (int k = 0; k < 2; k++) begin
            ic_gnt = 1'b0; ic_rsp_valid = 1'b1; ic_rsp_epoch = 2'd0; ic_rsp_bundle = rnd_bundle();
            #1;
            if (phit !== 1'b0 || occ !== 3'd1) begin n_err++; $display("FAIL stale_drop k=%0d phit=%0b occ=%0d exp 0/1", k, phit, occ); end n_cmp++;
            nxt();
        end
        ic_rsp_valid = 1'b1; ic_rsp_epoch = 2'd1; ic_rsp_bundle = x;
        #1;
        if (phit !== 1'b0) begin n_err++; $display("FAIL stale_last_drop phit=%0b exp=0", phit); end n_cmp++;
        nxt();
        idle();
        #1;
        if (phit !== 1'b1 || bundle !== x) begin n_err++; $display("FAIL stale_fill phit=%0b bundle=%h exp 1/%h", phit, bundle, x); end n_cmp++;
        if (bundle_ip !== 32'h2000 || ip_mask !== 3'b111) begin n_err++; $display("FAIL stale_head ip=%h mask=%b", bundle_ip, ip_mask); end n_cmp++;
        nxt();
    endtask

    task automatic test_simultaneous();
        logic [BW-1:0] da, db, dc;
        da = rnd_bundle(); db = rnd_bundle(); dc = rnd_bundle();
        do_reset();
        ic_gnt = 1'b1; #1; nxt();
        ic_gnt = 1'b1; #1; nxt();
        ic_gnt = 1'b0; ic_rsp_valid = 1'b1; ic_rsp_epoch = 2'd0; ic_rsp_bundle = da; #1; nxt();
        nextb = 1'b1; ic_gnt = 1'b1; ic_rsp_bundle = db;
        #1;
        if (occ !== 3'd2 || phit !== 1'b1 || bundle !== da || ic_req !== 1'b1) begin n_err++; $display("FAIL sim_pre occ=%0d phit=%0b req=%0b", occ, phit, ic_req); end n_cmp++;
        nxt();
        ic_gnt = 1'b0; ic_rsp_bundle = dc;
        #1;
        if (occ !== 3'd2) begin n_err++; $display("FAIL sim_occ got=%0d exp=2", occ); end n_cmp++;
        if (phit !== 1'b1 || bundle !== db || bundle_ip !== 32'hFFFC0010) begin n_err++; $display("FAIL sim_order phit=%0b ip=%h bundle=%h", phit, bundle_ip, bundle); end n_cmp++;
        nxt();
        nextb = 1'b0; ic_rsp_valid = 1'b0; ic_gnt = 1'b1;
        #1;
        if (occ !== 3'd1 || phit !== 1'b1 || bundle !== dc || bundle_ip !== 32'hFFFC0020) begin n_err++; $display("FAIL sim_third occ=%0d ip=%h", occ, bundle_ip); end n_cmp++;
        nxt();
    endtask

    task automatic test_redirect_collision();
        logic [BW-1:0] dn;
        dn = rnd_bundle();
        idle();
        redirect = 1'b1; redirect_ip = 32'h3004; nextb = 1'b1; ic_gnt = 1'b1;
        ic_rsp_valid = 1'b1; ic_rsp_epoch = 2'd0; ic_rsp_bundle = rnd_bundle();
        #1;
        if (ic_req !== 1'b0 || occ !== 3'd2 || phit !== 1'b1) begin n_err++; $display("FAIL coll_cycle req=%0b occ=%0d phit=%0b exp 0/2/1", ic_req, occ, phit); end n_cmp++;
        nxt();
        idle();
        ic_gnt = 1'b1;
        #1;
        if (occ !== 3'd0 || phit !== 1'b0) begin n_err++; $display("FAIL coll_cleared occ=%0d phit=%0b exp 0/0", occ, phit); end n_cmp++;
        if (ic_req_addr !== 32'h3000 || ic_req_epoch !== 2'd1) begin n_err++; $display("FAIL coll_pc addr=%h ep=%0d exp 3000/1", ic_req_addr, ic_req_epoch); end n_cmp++;
        nxt();
        idle();
        ic_rsp_valid = 1'b1; ic_rsp_epoch = 2'd1; ic_rsp_bundle = dn;
        #1; nxt();
        idle();
        #1;
        if (phit !== 1'b1 || bundle_ip !== 32'h3004 || ip_mask !== 3'b011 || bundle !== dn) begin
            n_err++; $display("FAIL coll_first_entry phit=%0b ip=%h mask=%b exp 1/3004/011", phit, bundle_ip, ip_mask);
        end n_cmp++;
        nxt();
    endtask

    // Random traffic against a queue model; the I-cache echoes epochs in order, including stale ones.
    task automatic test_random();
        ent_t          mq[$];
        req_t          rq[$];
        int            mfill;
        logic [AW-1:0] mpc;
        logic [EPW-1:0] mep;
        logic          allow, use_rsp, exp_req, exp_phit, gnt_now;
        do_reset();
        mfill = 0; mpc = 32'hFFFC0000; mep = '0;
        for (int k = 0; k < 3000; k++) begin
            allow = 1'b1;
            foreach (rq[i]) if (rq[i].ep == mep + 2'd1) allow = 1'b0;
            idle();
            redirect    = allow && ($urandom_range(0, 19) == 0);
            redirect_ip = $urandom;
            ic_gnt      = ($urandom_range(0, 3) != 0);
            nextb       = ($urandom_range(0, 2) != 0);
            use_rsp     = (rq.size() > 0) && ($urandom_range(0, 2) != 0);
            if (use_rsp) begin
                ic_rsp_valid = 1'b1; ic_rsp_epoch = rq[0].ep; ic_rsp_bundle = rq[0].data;
            end else begin
                ic_rsp_epoch = 2'($urandom); ic_rsp_bundle = rnd_bundle();
            end
            #1;
            exp_req  = !redirect && (mq.size() < DEPTH);
            exp_phit = (mfill > 0);
            if (ic_req !== exp_req) begin n_err++; $display("FAIL rnd_req k=%0d got=%0b exp=%0b", k, ic_req, exp_req); end n_cmp++;
            if (occ !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_occ k=%0d got=%0d exp=%0d", k, occ, mq.size()); end n_cmp++;
            if (phit !== exp_phit) begin n_err++; $display("FAIL rnd_phit k=%0d got=%0b exp=%0b", k, phit, exp_phit); end n_cmp++;
            if (ic_req_epoch !== mep) begin n_err++; $display("FAIL rnd_epoch k=%0d got=%0d exp=%0d", k, ic_req_epoch, mep); end n_cmp++;
            if (exp_req) begin
                if (ic_req_addr !== {mpc[AW-1:4], 4'b0000}) begin n_err++; $display("FAIL rnd_addr k=%0d got=%h exp=%h", k, ic_req_addr, {mpc[AW-1:4], 4'b0000}); end n_cmp++;
            end
            if (exp_phit) begin
                if (bundle !== mq[0].data || bundle_ip !== mq[0].ip || ip_mask !== mq[0].mask) begin
                    n_err++; $display("FAIL rnd_head k=%0d ip=%h/%h mask=%b/%b bundle=%h/%h", k, bundle_ip, mq[0].ip, ip_mask, mq[0].mask, bundle, mq[0].data);
                end n_cmp++;
            end
            gnt_now = exp_req && ic_gnt;
            if (redirect) begin
                mq.delete(); mfill = 0; mep = mep + 2'd1; mpc = redirect_ip;
            end else begin
                if (ic_rsp_valid && ic_rsp_epoch == mep && mfill < mq.size()) begin
                    mq[mfill].data = ic_rsp_bundle; mfill++;
                end
                if (nextb && exp_phit) begin void'(mq.pop_front()); mfill--; end
                if (gnt_now) begin
                    mq.push_back('{ip: mpc, mask: mask_of(mpc[3:2]), data: '0});
                    mpc = {mpc[AW-1:4] + 28'd1, 4'b0000};
                end
            end
            if (use_rsp) void'(rq.pop_front());
            if (gnt_now) rq.push_back('{ep: mep, data: rnd_bundle()});
            nxt();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_fill_sequence();
        test_full_hold();
        test_redirect_slot();
        test_stale_drop();
        test_simultaneous();
        test_redirect_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
